// File: rtl/data_mem_responder.sv
// Load/store responder: word-addressed synchronous data RAM behind a req/ack handshake
// with programmable wait states. Define DMEM_STATS_EN to add saturating access counters.
module data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 200,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
`ifdef DMEM_STATS_EN
    output logic [15:0]       load_cnt,
    output logic [15:0]       store_cnt,
    output logic [7:0]        err_cnt,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    localparam logic [3:0]      CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                go_resp;
    logic                acc_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic                in_range;

    // With zero wait states the access happens on the capture edge, so use the live inputs.
    assign acc_we    = (state_q == ST_IDLE) ? we    : we_q;
    assign acc_addr  = (state_q == ST_IDLE) ? addr  : addr_q;
    assign acc_wdata = (state_q == ST_IDLE) ? wdata : wdata_q;
    assign in_range  = {1'b0, acc_addr} < DEPTH_L;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        err_d   = err_q;
        go_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = CNT_INIT;
                    if (WAIT_CYCLES == 0) go_resp = 1'b1;
                    else                  state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) go_resp = 1'b1;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
        if (go_resp) begin
            state_d = ST_RESP;
            ack_d   = 1'b1;
            err_d   = !in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    // RAM write is gated by reset so an aborted store never lands.
    always_ff @(posedge clk) begin
        if (go_resp && in_range && acc_we && !reset) begin
            mem_q[acc_addr] <= acc_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (go_resp) begin
            if (!in_range)   rdata_q <= '0;
            else if (!acc_we) rdata_q <= mem_q[acc_addr];
        end
    end

    assign ack   = ack_q;
    assign err   = err_q;
    assign rdata = rdata_q;
    assign busy  = (state_q != ST_IDLE);

`ifdef DMEM_STATS_EN
    logic [15:0] load_cnt_q, load_cnt_d;
    logic [15:0] store_cnt_q, store_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    always_comb begin
        load_cnt_d  = load_cnt_q;
        store_cnt_d = store_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (go_resp) begin
            if (!in_range) begin
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 8'd1;
            end else if (acc_we) begin
                if (store_cnt_q != '1) store_cnt_d = store_cnt_q + 16'd1;
            end else begin
                if (load_cnt_q != '1) load_cnt_d = load_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule
